// File: rtl/oci_debug_pkg.sv
// rtl/oci_debug_pkg.sv - shared types and jdo field positions for the OCI debug memory controller
package oci_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_src_t;

  localparam int JDO_RD_BIT     = 34;
  localparam int JDO_ERRCLR_BIT = 36;
  localparam int JDO_ADDR_LSB   = 10;
  localparam int JDO_DATA_LSB   = 3;

endpackage

// File: rtl/oci_debug_mem_arb.sv
// rtl/oci_debug_mem_arb.sv - two-requester alternating-priority arbiter (CPU vs JTAG)
module oci_debug_mem_arb
  import oci_debug_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_cpu,
  input  logic       req_jtag,
  input  logic       accept,
  output logic       gnt_valid,
  output grant_src_t gnt_src
);

  grant_src_t last_grant;

  // Lone requester wins; on contention the side not served last wins
  always_comb begin
    gnt_valid = req_cpu | req_jtag;
    gnt_src   = GNT_CPU;
    if (req_jtag && (!req_cpu || last_grant == GNT_CPU)) begin
      gnt_src = GNT_JTAG;
    end
  end

  // Remember who was served so the other side gets the next tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_CPU;
    end else if (accept && gnt_valid) begin
      last_grant <= gnt_src;
    end
  end

endmodule

// File: rtl/oci_debug_mem_ctrl.sv
// rtl/oci_debug_mem_ctrl.sv - JTAG/CPU debug RAM controller; OCI_DEBUG_MEM_CPU_WRITE_EN lets CPU writes reach the RAM
module oci_debug_mem_ctrl
  import oci_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state, state_nxt;
  grant_src_t        cur_src, arb_src;
  logic              arb_valid;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              pend_valid, pend_write;
  logic              cpu_req, cpu_we, jtag_done, cpu_done, slot_busy, any_strobe;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37], jdo[35], jdo[2:0]};

  assign cpu_req    = avs_read | avs_write;
  assign jtag_done  = (state == ST_DONE) && (cur_src == GNT_JTAG);
  assign cpu_done   = (state == ST_DONE) && (cur_src == GNT_CPU);
  // The slot frees in the DONE cycle of its own access so a strobe 3 cycles later is accepted
  assign slot_busy  = pend_valid && !jtag_done;
  assign any_strobe = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;

`ifdef OCI_DEBUG_MEM_CPU_WRITE_EN
  assign cpu_we = avs_write;
`else
  assign cpu_we = 1'b0;
`endif

  oci_debug_mem_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_cpu   (cpu_req && state == ST_IDLE),
    .req_jtag  (pend_valid && state == ST_IDLE),
    .accept    (state == ST_IDLE),
    .gnt_valid (arb_valid),
    .gnt_src   (arb_src)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: every granted access spends one cycle in ACC and one in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_valid) state_nxt = ST_ACC;
      ST_ACC:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CPU handshake: released only in the DONE cycle of its own access
  always_comb begin
    avs_waitrequest = cpu_req && !cpu_done;
    avs_readdata    = cpu_done ? ram_rdata : 32'd0;
  end

  // RAM strobes, JTAG pending slot and monitor registers; strobes override DONE updates
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_src       <= GNT_CPU;
      ram_addr      <= '0;
      ram_wdata     <= 32'd0;
      ram_we        <= 1'b0;
      ram_re        <= 1'b0;
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      mon_a_reg     <= '0;
      MonDReg       <= 32'd0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      if (state == ST_IDLE && arb_valid) begin
        cur_src <= arb_src;
        if (arb_src == GNT_JTAG) begin
          ram_addr  <= mon_a_reg;
          ram_wdata <= MonDReg;
          ram_we    <= pend_write;
          ram_re    <= !pend_write;
        end else begin
          ram_addr  <= avs_address;
          ram_wdata <= avs_writedata;
          ram_we    <= cpu_we;
          ram_re    <= !avs_write;
        end
      end
      if (jtag_done) begin
        if (!pend_write) MonDReg <= ram_rdata;
        monitor_ready <= 1'b1;
        mon_a_reg     <= mon_a_reg + 1'b1;
        pend_valid    <= 1'b0;
      end
      if (any_strobe) begin
        if (slot_busy) begin
          monitor_error <= 1'b1;
        end else if (take_action_ocimem_b) begin
          MonDReg       <= jdo[JDO_DATA_LSB +: 32];
          pend_valid    <= 1'b1;
          pend_write    <= 1'b1;
          monitor_ready <= 1'b0;
        end else if (take_action_ocimem_a) begin
          mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_ERRCLR_BIT]) monitor_error <= 1'b0;
          if (jdo[JDO_RD_BIT]) begin
            pend_valid    <= 1'b1;
            pend_write    <= 1'b0;
            monitor_ready <= 1'b0;
          end
        end else begin
          pend_valid    <= 1'b1;
          pend_write    <= 1'b0;
          monitor_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_oci_debug_mem_ctrl.sv
// tb/tb_oci_debug_mem_ctrl.sv - scoreboard bench for oci_debug_mem_ctrl with a behavioural debug RAM
module tb_oci_debug_mem_ctrl;

  localparam int ADDR_W = 8;
  localparam int K_A = 0;
  localparam int K_N = 1;
  localparam int K_B = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              tk_a, tk_n, tk_b;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata, avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              ram_we, ram_re;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  logic [31:0] mem [0:255];
  logic [31:0] jtag_exp_q [$];
  logic [31:0] cpu_exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat;

  oci_debug_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (tk_a),
    .take_no_action_ocimem_a (tk_n),
    .take_action_ocimem_b    (tk_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic strobe(input int kind, input logic [37:0] d);
    jdo = d;
    case (kind)
      K_A:     tk_a = 1'b1;
      K_N:     tk_n = 1'b1;
      default: tk_b = 1'b1;
    endcase
    @(negedge clk);
    tk_a = 1'b0;
    tk_n = 1'b0;
    tk_b = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    while (monitor_ready !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_ready"}, {31'd0, monitor_ready}, 32'd1);
  endtask

  task automatic jtag_pop(input string tag);
    if (jtag_exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check({tag, "_mondreg"}, MonDReg, jtag_exp_q.pop_front());
  endtask

  task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [31:0] d, output int cycles);
    avs_address   = a;
    avs_writedata = d;
    avs_read      = !wr;
    avs_write     = wr;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (avs_waitrequest && cycles < 30);
    if (!wr && cpu_exp_q.size() > 0) check("cpu_rdata", avs_readdata, cpu_exp_q.pop_front());
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4{i[7:0]}};
    mem[8'h10] = 32'hDEADBEEF;
    reset = 1'b1;
    jdo = '0; tk_a = 0; tk_n = 0; tk_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    repeat (3) @(negedge clk);

    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_ready",   {31'd0, monitor_ready}, 32'd1);
    check("rst_error",   {31'd0, monitor_error}, 32'd0);
    check("rst_ram_we",  {31'd0, ram_we}, 32'd0);
    check("rst_ram_re",  {31'd0, ram_re}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_avs_rdata", avs_readdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Address load with read, then post-incremented read
    jtag_exp_q.push_back(32'hDEADBEEF);
    strobe(K_A, (38'd1 << 34) | (38'h10 << 10));
    check("t1_busy", {31'd0, monitor_ready}, 32'd0);
    wait_ready("t1", lat);
    check("t1_lat", lat, 32'd3);
    jtag_pop("t1");
    jtag_exp_q.push_back(32'h11111111);
    strobe(K_N, 38'd0);
    wait_ready("t1b", lat);
    jtag_pop("t1b");

    // Writes across the address wrap
    strobe(K_A, 38'hFF << 10);
    check("t2_noread_ready", {31'd0, monitor_ready}, 32'd1);
    strobe(K_B, 38'd1 << 3);
    wait_ready("t2a", lat);
    strobe(K_B, 38'd2 << 3);
    wait_ready("t2b", lat);
    check("t2_mem_ff", mem[8'hFF], 32'd1);
    check("t2_mem_00", mem[8'h00], 32'd2);
    check("t2_mondreg", MonDReg, 32'd2);
    jtag_exp_q.push_back(32'h01010101);
    strobe(K_N, 38'd0);
    wait_ready("t2c", lat);
    jtag_pop("t2c");

    // Uncontended CPU read leaves last_grant at CPU
    cpu_exp_q.push_back(32'h20202020);
    cpu_access(1'b0, 8'h20, 32'd0, lat);
    check("t3_cpu_lat", lat, 32'd2);
    @(negedge clk);

    // JTAG pending and CPU read contend: JTAG first, CPU 3 cycles late
    jtag_exp_q.push_back(32'h30303030);
    strobe(K_A, (38'd1 << 34) | (38'h30 << 10));
    cpu_exp_q.push_back(32'h21212121);
    cpu_access(1'b0, 8'h21, 32'd0, lat);
    check("t3_contend_lat", lat, 32'd5);
    check("t3_ready", {31'd0, monitor_ready}, 32'd1);
    jtag_pop("t3");
    @(negedge clk);

    // Overrun: second strobe one cycle later is dropped and flagged
    jtag_exp_q.push_back(32'h31313131);
    jdo = 38'd0;
    tk_n = 1'b1;
    @(negedge clk);
    tk_n = 1'b0;
    jdo = 38'hBAD << 3;
    tk_b = 1'b1;
    @(negedge clk);
    tk_b = 1'b0;
    check("t4_error_set", {31'd0, monitor_error}, 32'd1);
    wait_ready("t4", lat);
    jtag_pop("t4");
    check("t4_mem_32", mem[8'h32], 32'h32323232);
    strobe(K_A, 38'd1 << 36);
    check("t4_error_clr", {31'd0, monitor_error}, 32'd0);

    // CPU write: RAM update depends on build, timing does not
    cpu_access(1'b1, 8'h20, 32'hA5A5A5A5, lat);
    check("t5_wr_lat", lat, 32'd2);
    @(negedge clk);
`ifdef OCI_DEBUG_MEM_CPU_WRITE_EN
    check("t5_mem_20", mem[8'h20], 32'hA5A5A5A5);
`else
    check("t5_mem_20", mem[8'h20], 32'h20202020);
`endif

    // Reset taken on the edge that would start a JTAG write
    strobe(K_A, 38'h40 << 10);
    strobe(K_B, 38'h77 << 3);
    reset = 1'b1;
    @(negedge clk);
    check("t6_ram_we", {31'd0, ram_we}, 32'd0);
    check("t6_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("t6_mondreg", MonDReg, 32'd0);
    check("t6_ready", {31'd0, monitor_ready}, 32'd1);
    check("t6_error", {31'd0, monitor_error}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_mem_40", mem[8'h40], 32'h40404040);
    check("t6_idle_we", {31'd0, ram_we}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oci_debug_mem_ctrl.md
# oci_debug_mem_ctrl

On-chip-instrumentation debug memory controller for the Nios II debug module, clocked on the system clock. It consumes the decoded JTAG debug-slave strobes (`take_action_ocimem_*`) and the `jdo` shift data, and arbitrates JTAG and CPU-side (Avalon debug_mem_slave) accesses to a single-port synchronous debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG capture path.

## Interface
- `ADDR_W`, default 8: word-address width of the debug RAM.
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `jdo`  in  38: JTAG data, stable while any strobe is high.
- `take_action_ocimem_a`  in  1: load address; optional read.
- `take_no_action_ocimem_a`  in  1: read at current address, then post-increment.
- `take_action_ocimem_b`  in  1: write `jdo[34:3]` at current address, then post-increment.
- `avs_address`  in  ADDR_W: CPU word address.
- `avs_read`, `avs_write`  in  1: CPU requests; held until waitrequest low.
- `avs_writedata`  in  32: CPU write data.
- `avs_readdata`  out  32: CPU read data, valid when `avs_read` and not `avs_waitrequest`.
- `avs_waitrequest`  out  1: stall.
- `ram_addr`  out  ADDR_W: registered RAM address.
- `ram_wdata`  out  32: registered RAM write data.
- `ram_we`, `ram_re`  out  1: registered RAM strobes.
- `ram_rdata`  in  32: RAM read data, 1-cycle latency after `ram_re`.
- `MonDReg`  out  32: monitor data register.
- `monitor_ready`  out  1: last JTAG access complete.
- `monitor_error`  out  1: sticky overrun flag.

## Operation
- `MonAReg` (ADDR_W) is internal and wraps modulo 2^ADDR_W on post-increment.
- `take_action_ocimem_a`:
  - `MonAReg <= jdo[10+ADDR_W-1:10]`.
  - If `jdo[36]`=1, clear `monitor_error`.
  - If `jdo[34]`=1, queue a JTAG read. Otherwise no RAM access and `monitor_ready` is unchanged.
- `take_no_action_ocimem_a`: queue a JTAG read at `MonAReg`.
- `take_action_ocimem_b`: `MonDReg <= jdo[34:3]`; queue a JTAG write of that value at `MonAReg`.
- Post-increment happens when a JTAG access completes.
- JTAG pending slot is one deep. Queuing clears `monitor_ready`.
- A strobe arriving while the slot is occupied is dropped: the slot is unchanged and `monitor_error` is set.
- If more than one strobe is high in the same cycle, the priority is ocimem_b, then ocimem_a, then no_action_ocimem_a. The losers are ignored, with no error.
- FSM:
  - IDLE → ACC on grant. Grant source is JTAG pending or CPU request.
  - ACC → DONE.
  - DONE → IDLE.
- Arbitration: if only one source is requesting, it wins. If both are requesting, the source not granted last wins. `last_grant` resets to CPU.
- ACC: `ram_re` or `ram_we` is high for exactly one cycle, with `ram_addr`/`ram_wdata` registered.
- DONE, JTAG read: `MonDReg <= ram_rdata`.
- DONE, JTAG access of either kind: `monitor_ready <= 1` and `MonAReg++`.
- DONE, CPU access: `avs_waitrequest`=0 for one cycle, with `avs_readdata = ram_rdata`.
- CPU requests are sampled only in IDLE. `avs_waitrequest` is high whenever `avs_read|avs_write` is high and the FSM is not in DONE for that CPU access.
- Reset values: `MonDReg`=0, `MonAReg`=0, `monitor_ready`=1, `monitor_error`=0, `ram_we`/`ram_re`=0, `ram_addr`/`ram_wdata`=0, `avs_readdata`=0, state IDLE, pending slot empty.
- Reset mid-access aborts the access. `ram_we` is 0 in the cycle after reset is sampled. The aborted CPU request is re-served after reset if the CPU still holds it.

## Timing
- Strobe sampled at edge E0 → pending.
- E1: grant, ACC entered, RAM strobes valid.
- E2: DONE.
- E3: `MonDReg`/`monitor_ready` updated; visible in the cycle after E3. Total 3 edges.
- CPU access with no contention: waitrequest low in the cycle after 2 edges from the request being sampled. Minimum CPU read latency is 3 cycles including the request cycle.
- Contention adds at most one full access (3 cycles).
- Back-to-back JTAG strobes must be ≥3 cycles apart to avoid error. The JTAG clock ratio guarantees this in normal use.

## Configuration
- `OCI_DEBUG_MEM_CPU_WRITE_EN` defined:
  - CPU writes reach the RAM.
- Undefined:
  - CPU writes complete with normal waitrequest timing but `ram_we` stays 0, making the RAM read-only from the CPU side.
  - JTAG writes are unaffected.

## Structure
- Shared package `oci_debug_pkg` holds:
  - FSM state enum (IDLE, ACC, DONE).
  - `jdo` field bit-position constants (`JDO_RD_BIT`=34, `JDO_ERRCLR_BIT`=36, `JDO_ADDR_LSB`=10, `JDO_DATA_LSB`=3).
  - grant-source enum.
- One sub-module, `oci_debug_mem_arb`: two-requester alternating-priority arbiter with a `last_grant` register.

## Test plan
- Load address 0x10 via ocimem_a (`jdo[34]`=1) with RAM[0x10]=0xDEADBEEF → after 3 edges `MonDReg`=0xDEADBEEF, `monitor_ready`=1, `MonAReg`=0x11.
- ocimem_b ×2 with data 0x1, 0x2 starting at 0xFF → RAM[0xFF]=0x1, RAM[0x00]=0x2 (address wrap).
- CPU read and JTAG read requested in the same cycle, `last_grant`=CPU → JTAG served first, CPU waitrequest low 3 cycles later.
- Second strobe 1 cycle after the first → `monitor_error`=1, first access completes normally. Then ocimem_a with `jdo[36]`=1 → error cleared.
- CPU write 0xA5A5A5A5 to 0x20: macro defined → RAM[0x20] updated. Macro undefined → RAM unchanged, waitrequest timing identical.
- Reset asserted in ACC of a JTAG write → no RAM change, all outputs at reset values next cycle.
